// File: rtl/omr_sheet_loader.sv
// rtl/omr_sheet_loader.sv - OMR scanner row collector, key latch and student sheet presenter
//
// Purpose: collects one bubble row per beat into an answer word, sanitises each row
//    (one-hot kept, anything else zeroed and flagged), latches good key sheets and
//    presents student sheets downstream through a valid/ready handshake.
// Ports:
//    clk, reset           clock, synchronous active-high reset
//    row_valid/row_ready  scanner row handshake; row_data bubbles (bit0=A .. bit3=D)
//    row_first            row is question 0 of a new sheet
//    row_is_key           sheet is an answer key (sampled with row_first)
//    key_answers          held key word, key_valid set once a good key is loaded
//    key_err              1-cycle pulse when a key sheet has a blank/multi-mark row
//    sheet_answers        sanitised student word, sheet_invalid per-question flags
//    sheet_valid/ready    student sheet handshake to the grader
//    frame_err            1-cycle pulse on a row_first framing violation
//    sheet_count          accepted student sheets, saturating
module omr_sheet_loader #(
   parameter int NUM_Q = 10,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 row_valid,
   output logic                 row_ready,
   input  logic [3:0]           row_data,
   input  logic                 row_first,
   input  logic                 row_is_key,
   output logic [4*NUM_Q-1:0]   key_answers,
   output logic                 key_valid,
   output logic                 key_err,
   output logic [4*NUM_Q-1:0]   sheet_answers,
   output logic [NUM_Q-1:0]     sheet_invalid,
   output logic                 sheet_valid,
   input  logic                 sheet_ready,
   output logic                 frame_err,
   output logic [CNT_W-1:0]     sheet_count
);

   localparam int IDX_W = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_Q - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_PRESENT = 2'd2;

   logic [1:0]             state;
   logic [IDX_W-1:0]       idx;
   logic                   is_key;
   logic [4*NUM_Q-1:0]     acc_answers;
   logic [NUM_Q-1:0]       acc_invalid;

   logic                   beat;
   logic                   onehot;
   logic                   take;
   logic                   bad_frame;
   logic                   last;
   logic                   cur_key;
   logic [IDX_W-1:0]       pos;
   logic [4*NUM_Q-1:0]     next_answers;
   logic [NUM_Q-1:0]       next_invalid;

   assign row_ready = (state != S_PRESENT);

   always_comb begin
      beat      = row_valid && row_ready;
      onehot    = (row_data == 4'b0001) || (row_data == 4'b0010) ||
                  (row_data == 4'b0100) || (row_data == 4'b1000);
      // A row_first beat always restarts at question 0 with a clean accumulator,
      // so a partial sheet interrupted by a new sheet leaves nothing behind.
      pos       = row_first ? '0 : idx;
      cur_key   = row_first ? row_is_key : is_key;
      take      = beat && (row_first || (state == S_COLLECT));
      bad_frame = beat && (((state == S_IDLE) && !row_first) ||
                           ((state == S_COLLECT) && row_first));
      last      = (pos == LAST_IDX);
      next_answers = row_first ? '0 : acc_answers;
      next_invalid = row_first ? '0 : acc_invalid;
      for (int i = 0; i < NUM_Q; i++) begin
         if (IDX_W'(i) == pos) begin
            next_answers[4*i +: 4] = onehot ? row_data : 4'b0000;
            next_invalid[i]        = !onehot;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         idx           <= '0;
         is_key        <= 1'b0;
         acc_answers   <= '0;
         acc_invalid   <= '0;
         key_answers   <= '0;
         key_valid     <= 1'b0;
         key_err       <= 1'b0;
         sheet_answers <= '0;
         sheet_invalid <= '0;
         sheet_valid   <= 1'b0;
         frame_err     <= 1'b0;
         sheet_count   <= '0;
      end else begin
         frame_err <= bad_frame;
         key_err   <= 1'b0;
         if (take) begin
            acc_answers <= next_answers;
            acc_invalid <= next_invalid;
            is_key      <= cur_key;
            if (last) begin
               idx <= '0;
               if (cur_key) begin
                  state <= S_IDLE;
                  if (|next_invalid) begin
                     key_err <= 1'b1;
                  end else begin
                     key_answers <= next_answers;
                     key_valid   <= 1'b1;
                  end
               end else begin
                  state         <= S_PRESENT;
                  sheet_answers <= next_answers;
                  sheet_invalid <= next_invalid;
                  sheet_valid   <= 1'b1;
               end
            end else begin
               idx   <= pos + IDX_W'(1);
               state <= S_COLLECT;
            end
         end
         if ((state == S_PRESENT) && sheet_ready) begin
            sheet_valid <= 1'b0;
            state       <= S_IDLE;
            if (sheet_count != {CNT_W{1'b1}}) begin
               sheet_count <= sheet_count + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_omr_sheet_loader.sv
// tb/tb_omr_sheet_loader.sv - self-checking bench for omr_sheet_loader
module tb_omr_sheet_loader;

   localparam int NQ = 10;

   logic            clk = 1'b0;
   logic            reset;
   logic            row_valid;
   logic            row_ready;
   logic [3:0]      row_data;
   logic            row_first;
   logic            row_is_key;
   logic [4*NQ-1:0] key_answers;
   logic            key_valid;
   logic            key_err;
   logic [4*NQ-1:0] sheet_answers;
   logic [NQ-1:0]   sheet_invalid;
   logic            sheet_valid;
   logic            sheet_ready;
   logic            frame_err;
   logic [7:0]      sheet_count;

   omr_sheet_loader #(.NUM_Q(NQ), .CNT_W(8)) dut (
      .clk(clk), .reset(reset),
      .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
      .row_first(row_first), .row_is_key(row_is_key),
      .key_answers(key_answers), .key_valid(key_valid), .key_err(key_err),
      .sheet_answers(sheet_answers), .sheet_invalid(sheet_invalid),
      .sheet_valid(sheet_valid), .sheet_ready(sheet_ready),
      .frame_err(frame_err), .sheet_count(sheet_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference state, advanced at sheet granularity
   logic [4*NQ-1:0] m_key;
   logic            m_kv;
   int              m_count;

   typedef struct {
      logic            is_key;
      logic [4*NQ-1:0] rows;
      int              ready_delay;
      logic [4*NQ-1:0] e_ans;
      logic [NQ-1:0]   e_inv;
   } vec_t;

   vec_t tbl[5];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // a row counts as answered only when exactly one bubble is marked
   task automatic model_sheet(input logic [4*NQ-1:0] rows,
                              output logic [4*NQ-1:0] ans, output logic [NQ-1:0] inv);
      logic [3:0] nib;
      ans = '0;
      inv = '0;
      for (int i = 0; i < NQ; i++) begin
         nib = rows[4*i +: 4];
         if ($countones(nib) == 1) ans[4*i +: 4] = nib;
         else inv[i] = 1'b1;
      end
   endtask

   task automatic apply_sheet(input logic is_key, input logic [4*NQ-1:0] rows,
                              input int ready_delay, input logic ferr_first,
                              input logic [4*NQ-1:0] e_ans, input logic [NQ-1:0] e_inv);
      logic ok;
      ok = (e_inv == '0);
      for (int i = 0; i < NQ; i++) begin
         row_valid  = 1'b1;
         row_first  = (i == 0);
         row_is_key = (i == 0) ? is_key : 1'($urandom);
         row_data   = rows[4*i +: 4];
         tick();
         check("beat_frame_err", frame_err, (i == 0) && ferr_first);
         if (i < NQ - 1) begin
            check("beat_row_ready", row_ready, 1);
            check("beat_no_sheet", sheet_valid, 0);
         end
      end
      row_valid = 1'b0;
      row_first = 1'b0;
      if (is_key) begin
         check("key_answers", key_answers, ok ? e_ans : m_key);
         check("key_valid", key_valid, ok ? 1'b1 : m_kv);
         check("key_err", key_err, !ok);
         check("key_no_sheet", sheet_valid, 0);
         check("key_row_ready", row_ready, 1);
         if (ok) begin
            m_key = e_ans;
            m_kv  = 1'b1;
         end
         tick();
         check("key_err_pulse", key_err, 0);
      end else begin
         check("sheet_valid", sheet_valid, 1);
         check("present_row_ready", row_ready, 0);
         check("sheet_answers", sheet_answers, e_ans);
         check("sheet_invalid", sheet_invalid, e_inv);
         check("key_held", key_answers, m_key);
         for (int d = 0; d < ready_delay; d++) begin
            // rows offered while presenting must be ignored without error
            row_valid  = 1'b1;
            row_first  = 1'b1;
            row_data   = 4'($urandom);
            tick();
            check("hold_valid", sheet_valid, 1);
            check("hold_answers", sheet_answers, e_ans);
            check("hold_invalid", sheet_invalid, e_inv);
            check("hold_row_ready", row_ready, 0);
            check("hold_frame_err", frame_err, 0);
            check("hold_count", sheet_count, m_count);
            check("hold_key", key_answers, m_key);
         end
         sheet_ready = 1'b1;
         tick();
         sheet_ready = 1'b0;
         row_valid   = 1'b0;
         row_first   = 1'b0;
         if (m_count < 255) m_count++;
         check("done_valid", sheet_valid, 0);
         check("done_row_ready", row_ready, 1);
         check("done_count", sheet_count, m_count);
         check("done_answers_held", sheet_answers, e_ans);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [4*NQ-1:0] rows, ans;
      logic [NQ-1:0]   inv;
      logic            k;

      tbl[0] = '{1'b1, 40'h2184218421, 0, 40'h2184218421, 10'b0000000000};
      tbl[1] = '{1'b0, 40'h2184218421, 5, 40'h2184218421, 10'b0000000000};
      tbl[2] = '{1'b0, 40'h2164210421, 1, 40'h2104210421, 10'b0010001000};
      tbl[3] = '{1'b1, 40'h2184218423, 0, 40'h2184218420, 10'b0000000001};
      tbl[4] = '{1'b0, 40'h8421842184, 2, 40'h8421842184, 10'b0000000000};

      reset = 1'b1; row_valid = 1'b0; row_data = 4'd0; row_first = 1'b0;
      row_is_key = 1'b0; sheet_ready = 1'b0;
      m_key = '0; m_kv = 1'b0; m_count = 0;
      tick();
      tick();
      check("rst_row_ready", row_ready, 1);
      check("rst_key", key_answers, 0);
      check("rst_key_valid", key_valid, 0);
      check("rst_sheet_valid", sheet_valid, 0);
      check("rst_answers", sheet_answers, 0);
      check("rst_count", sheet_count, 0);
      check("rst_frame_err", frame_err, 0);
      reset = 1'b0;
      tick();

      for (int t = 0; t < 5; t++)
         apply_sheet(tbl[t].is_key, tbl[t].rows, tbl[t].ready_delay, 1'b0,
                     tbl[t].e_ans, tbl[t].e_inv);

      // row without row_first while idle is dropped with a framing pulse
      row_valid = 1'b1; row_first = 1'b0; row_data = 4'b0001;
      tick();
      row_valid = 1'b0;
      check("idle_frame_err", frame_err, 1);
      check("idle_row_ready", row_ready, 1);
      tick();
      check("idle_frame_err_pulse", frame_err, 0);
      apply_sheet(1'b0, 40'h4444422222, 0, 1'b0, 40'h4444422222, '0);

      // restart at row 5: only the new rows must survive
      for (int i = 0; i < 5; i++) begin
         row_valid = 1'b1; row_first = (i == 0); row_is_key = 1'b0; row_data = 4'b1000;
         tick();
      end
      apply_sheet(1'b0, 40'h1111122222, 1, 1'b1, 40'h1111122222, '0);

      // reset during row 6 of a sheet
      for (int i = 0; i < 6; i++) begin
         row_valid = 1'b1; row_first = (i == 0); row_is_key = 1'b0; row_data = 4'b0100;
         tick();
      end
      reset = 1'b1; row_data = 4'b0001;
      tick();
      reset = 1'b0; row_valid = 1'b0; row_first = 1'b0;
      m_key = '0; m_kv = 1'b0; m_count = 0;
      check("midrst_row_ready", row_ready, 1);
      check("midrst_key", key_answers, 0);
      check("midrst_key_valid", key_valid, 0);
      check("midrst_sheet_valid", sheet_valid, 0);
      check("midrst_count", sheet_count, 0);
      check("midrst_frame_err", frame_err, 0);
      check("midrst_key_err", key_err, 0);
      apply_sheet(1'b0, 40'h8888844444, 0, 1'b0, 40'h8888844444, '0);

      // randomized sheets against the reference model
      for (int s = 0; s < 30; s++) begin
         k = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < NQ; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (k && $urandom_range(0, 2) != 0) r = 0;
            if (r < 6)      rows[4*i +: 4] = 4'b0001 << $urandom_range(0, 3);
            else if (r < 8) rows[4*i +: 4] = 4'b0000;
            else            rows[4*i +: 4] = 4'($urandom_range(0, 15));
         end
         model_sheet(rows, ans, inv);
         apply_sheet(k, rows, $urandom_range(0, 3), 1'b0, ans, inv);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
